// File: rtl/codec_intf_if.sv
// codec_intf_if: sample bus between the EQ engine and the codec transceiver.
// The EQ engine is the master (supplies results, consumes ADC samples).
interface codec_intf_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] lft_out;
    logic signed [DATA_W-1:0] rht_out;
    logic                     sequencing;
    logic        [DATA_W-1:0] lft_in;
    logic        [DATA_W-1:0] rht_in;
    logic                     valid;
    logic                     valid_rise;
    logic                     valid_fall;

    modport master (
        output lft_out, rht_out, sequencing,
        input  lft_in, rht_in, valid, valid_rise, valid_fall
    );

    modport slave (
        input  lft_out, rht_out, sequencing,
        output lft_in, rht_in, valid, valid_rise, valid_fall
    );
endinterface

// File: rtl/codec_intf.sv
// codec_intf: left-justified 16-bit stereo codec transceiver with MCLK/SCLK/LRCLK/RSTn generation.
// Define CODEC_RST_DLY_EN to hold codec RSTn low for RST_FRAMES frames after reset.
module codec_intf #(
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 10,
    parameter int SCLK_LOG2 = 5,
    parameter int MCLK_LOG2 = 2
`ifdef CODEC_RST_DLY_EN
    ,
    parameter int RST_FRAMES = 2
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    codec_intf_if.slave eq,
    input  logic        SDout,
    output logic        LRCLK,
    output logic        SCLK,
    output logic        MCLK,
    output logic        RSTn,
    output logic        SDin
);
    localparam int SH_W = 2 * DATA_W;

    logic [CNT_W-1:0] cnt;
    logic [SH_W-1:0]  rx_shft;
    logic [SH_W-1:0]  tx_shft;
    logic             valid_q;
    logic             frame_end;
    logic             half_end;
    logic             rx_stb;
    logic             tx_stb;

    // Codec clocks are plain counter bits, so they are glitch-free and 50% duty.
    assign MCLK  = cnt[MCLK_LOG2-1];
    assign SCLK  = cnt[SCLK_LOG2-1];
    assign LRCLK = cnt[CNT_W-1];
    assign SDin  = tx_shft[SH_W-1];

    assign frame_end = &cnt;
    assign half_end  = (cnt == {1'b0, {(CNT_W-1){1'b1}}});
    assign rx_stb    = (cnt[SCLK_LOG2-1:0] == {1'b0, {(SCLK_LOG2-1){1'b1}}});
    assign tx_stb    = &cnt[SCLK_LOG2-1:0];

`ifdef CODEC_RST_DLY_EN
    localparam int FRM_W = $clog2(RST_FRAMES + 1);
    logic [FRM_W-1:0] frm_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= '0;
            rx_shft       <= '0;
            tx_shft       <= '0;
            eq.lft_in     <= '0;
            eq.rht_in     <= '0;
            eq.valid      <= 1'b0;
            eq.valid_rise <= 1'b0;
            eq.valid_fall <= 1'b0;
            valid_q       <= 1'b0;
            RSTn          <= 1'b0;
`ifdef CODEC_RST_DLY_EN
            frm_cnt       <= '0;
`endif
        end else begin
            cnt <= cnt + CNT_W'(1);

            // Sample SDout on the SCLK rising edge.
            if (rx_stb)
                rx_shft <= {rx_shft[SH_W-2:0], SDout};

            // Load at frame end has priority; otherwise advance on SCLK falling edge.
            if (frame_end)
                tx_shft <= eq.sequencing ? {eq.lft_out, eq.rht_out} : '0;
            else if (tx_stb)
                tx_shft <= {tx_shft[SH_W-2:0], 1'b0};

            if (frame_end) begin
                eq.lft_in <= rx_shft[SH_W-1:DATA_W];
                eq.rht_in <= rx_shft[DATA_W-1:0];
                if (RSTn)
                    eq.valid <= 1'b1;
            end else if (half_end) begin
                eq.valid <= 1'b0;
            end

            valid_q       <= eq.valid;
            eq.valid_rise <= eq.valid & ~valid_q;
            eq.valid_fall <= ~eq.valid & valid_q;

`ifdef CODEC_RST_DLY_EN
            // Release the codec after RST_FRAMES complete frames; it rises at cnt 0.
            if (!RSTn && frame_end) begin
                if (frm_cnt == FRM_W'(RST_FRAMES - 1))
                    RSTn <= 1'b1;
                frm_cnt <= frm_cnt + FRM_W'(1);
            end
`else
            RSTn <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_codec_intf.sv
// tb_codec_intf: directed bench for codec_intf with ADC/DAC codec models and a reference frame counter.
// Covers reset, clock generation, rx latch/valid timing, tx load/sequencing, loopback.
module tb_codec_intf;
    logic clk;
    logic rst_n;
    logic SDout, LRCLK, SCLK, MCLK, RSTn, SDin;
    logic loop;
    logic [31:0] adc;
    logic [31:0] dac_sh;
    logic [9:0]  ref_cnt;

    int checks = 0;
    int failures = 0;
    int clk_err, n_vh, n_vr, n_vf;
    int mclk_h, sclk_h, lr_h, mclk_r, sclk_r, lr_r;
    logic mclk_p, sclk_p, lr_p;

    codec_intf_if #(.DATA_W(16)) eq ();

    codec_intf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .eq    (eq),
        .SDout (SDout),
        .LRCLK (LRCLK),
        .SCLK  (SCLK),
        .MCLK  (MCLK),
        .RSTn  (RSTn),
        .SDin  (SDin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame counter: the bench's own view of where the codec is in the frame.
    always @(posedge clk) ref_cnt <= rst_n ? ref_cnt + 10'd1 : 10'd0;

    // ADC model: left-justified, MSB first from cnt 0; optional loopback of SDin.
    assign SDout = loop ? SDin : adc[5'd31 - ref_cnt[9:5]];

    // DAC model: sample SDin while SCLK is high (just after its rising edge).
    always @(negedge clk)
        if (ref_cnt[4:0] == 5'h10)
            dac_sh <= {dac_sh[30:0], SDin};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        clk_err = 0; n_vh = 0; n_vr = 0; n_vf = 0;
        mclk_h = 0; sclk_h = 0; lr_h = 0; mclk_r = 0; sclk_r = 0; lr_r = 0;
        mclk_p = MCLK; sclk_p = SCLK; lr_p = LRCLK;
    endtask

    task automatic tick();
        @(negedge clk);
        if ({LRCLK, SCLK, MCLK} !== {ref_cnt[9], ref_cnt[4], ref_cnt[1]}) clk_err++;
        if (eq.valid)      n_vh++;
        if (eq.valid_rise) n_vr++;
        if (eq.valid_fall) n_vf++;
        if (MCLK)  mclk_h++;
        if (SCLK)  sclk_h++;
        if (LRCLK) lr_h++;
        if (MCLK && !mclk_p)  mclk_r++;
        if (SCLK && !sclk_p)  sclk_r++;
        if (LRCLK && !lr_p)   lr_r++;
        mclk_p = MCLK; sclk_p = SCLK; lr_p = LRCLK;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_lft_in"}, {16'h0, eq.lft_in}, 32'h0);
        chk({p, "_rht_in"}, {16'h0, eq.rht_in}, 32'h0);
        chk({p, "_valid"}, {31'h0, eq.valid}, 32'h0);
        chk({p, "_vrise"}, {31'h0, eq.valid_rise}, 32'h0);
        chk({p, "_vfall"}, {31'h0, eq.valid_fall}, 32'h0);
        chk({p, "_sdin"}, {31'h0, SDin}, 32'h0);
        chk({p, "_clks"}, {29'h0, LRCLK, SCLK, MCLK}, 32'h0);
        chk({p, "_rstn"}, {31'h0, RSTn}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; loop = 1'b0; adc = 32'hA5C3_3C5A;
        eq.sequencing = 1'b0; eq.lft_out = '0; eq.rht_out = '0;
        repeat (3) @(negedge clk);
        chk_reset("rst0");

        eq.sequencing = 1'b1; eq.lft_out = 16'sh8001; eq.rht_out = 16'sh7FFE;
        rst_n = 1'b1;
        clr_stats();
`ifdef CODEC_RST_DLY_EN
        ticks(1024);
        chk("dly_valid_f1", {31'h0, eq.valid}, 32'h0);
        ticks(1023);
        chk("dly_rstn_lo", {31'h0, RSTn}, 32'h0);
        tick();
        chk("dly_rstn_hi", {31'h0, RSTn}, 32'h1);
        ticks(1024);
        chk("dly_vrise_none", n_vr, 0);
        chk("dly_valid_on", {31'h0, eq.valid}, 32'h1);
        tick();
        chk("dly_vrise", {31'h0, eq.valid_rise}, 32'h1);
        chk("dly_clk_err", clk_err, 0);
        chk("dly_sclk_rises", sclk_r, 96);
`else
        ticks(1023);
        chk("pre_valid", n_vh, 0);
        chk("pre_vrise", n_vr, 0);
        chk("rstn_hi", {31'h0, RSTn}, 32'h1);
        tick();   // cnt wrapped: first frame latched
        chk("f1_valid", {31'h0, eq.valid}, 32'h1);
        chk("f1_lft_in", {16'h0, eq.lft_in}, 32'h0000_A5C3);
        chk("f1_rht_in", {16'h0, eq.rht_in}, 32'h0000_3C5A);
        chk("clk_err", clk_err, 0);
        chk("mclk_high", mclk_h, 512);
        chk("sclk_high", sclk_h, 512);
        chk("lrclk_high", lr_h, 512);
        chk("mclk_rises", mclk_r, 256);
        chk("sclk_rises", sclk_r, 32);
        chk("lrclk_rises", lr_r, 1);
        adc = 32'hFFFF_0000;
        clr_stats();
        tick();
        chk("f1_vrise", {31'h0, eq.valid_rise}, 32'h1);
        ticks(511);
        chk("f1_valid_off", {31'h0, eq.valid}, 32'h0);
        tick();
        chk("f1_vfall", {31'h0, eq.valid_fall}, 32'h1);
        eq.sequencing = 1'b0; eq.lft_out = 16'sh1111;
        ticks(511);
        chk("f2_dac", dac_sh, 32'h8001_7FFE);
        chk("f2_valid_len", n_vh, 512);
        chk("f2_vrise_cnt", n_vr, 1);
        chk("f2_vfall_cnt", n_vf, 1);
        chk("f2_lft_in", {16'h0, eq.lft_in}, 32'h0000_FFFF);
        chk("f2_rht_in", {16'h0, eq.rht_in}, 32'h0000_0000);
        adc = 32'h0001_8000;
        ticks(152);
        eq.sequencing = 1'b1;   // mid-frame pulse must be ignored
        ticks(700);
        eq.sequencing = 1'b0;
        ticks(172);
        chk("f3_dac_seq0", dac_sh, 32'h0);
        chk("f3_lft_in", {16'h0, eq.lft_in}, 32'h0000_0001);
        chk("f3_rht_in", {16'h0, eq.rht_in}, 32'h0000_8000);
        ticks(1024);
        chk("f4_dac_pulse", dac_sh, 32'h0);
        loop = 1'b1; eq.sequencing = 1'b1; eq.lft_out = 16'sh1234; eq.rht_out = -16'sh5433;
        ticks(1024);
        chk("f5_loop_lft0", {16'h0, eq.lft_in}, 32'h0);
        chk("f5_dac0", dac_sh, 32'h0);
        eq.sequencing = 1'b0;
        ticks(1024);
        chk("f6_loop_lft", {16'h0, eq.lft_in}, 32'h0000_1234);
        chk("f6_loop_rht", {16'h0, eq.rht_in}, 32'h0000_ABCD);
        chk("f6_dac", dac_sh, 32'h1234_ABCD);
        ticks(291);             // cnt = 0x123, mid-frame
        chk("mid_valid_pre", {31'h0, eq.valid}, 32'h1);
        rst_n = 1'b0;
        tick();
        chk_reset("mid");
        ticks(2);
        rst_n = 1'b1;
        clr_stats();
        ticks(1023);
        chk("re_valid_none", n_vh, 0);
        chk("re_vrise_none", n_vr, 0);
        chk("re_clk_err", clk_err, 0);
        tick();
        chk("re_valid", {31'h0, eq.valid}, 32'h1);
        chk("re_lft_in", {16'h0, eq.lft_in}, 32'h0);
        tick();
        chk("re_vrise", {31'h0, eq.valid_rise}, 32'h1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
